fta_bridge32to128: RTL and testbench



---
 rtl/fta_bus_pkg.sv | 95 +++++++++
 rtl/fta_lane_tag_table.sv | 45 ++++
 rtl/fta_bridge32to128.sv | 138 +++++++++++++
 tb/tb_fta_bridge32to128.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// FTA bus types shared by the 32-to-128 widening bridge: request/response
// structs, transfer-size enum, lane-tag entry and the byte-select steering helper.
package fta_bus_pkg;

  typedef logic [7:0] fta_tranid_t;

  typedef enum logic [2:0] {
    nul   = 3'd0,
    byt   = 3'd1,
    wyde  = 3'd2,
    tetra = 3'd3,
    octa  = 3'd4,
    hexi  = 3'd5
  } fta_size_t;

  typedef struct packed {
    logic [1:0]  om;
    logic [4:0]  cmd;
    fta_tranid_t tid;
    logic [1:0]  bte;
    logic [5:0]  blen;
    logic [2:0]  cti;
    logic [3:0]  seg;
    fta_size_t   sz;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  asid;
    logic [31:0] vadr;
    logic [31:0] padr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [7:0]  pl;
    logic [3:0]  pri;
    logic [3:0]  cache;
    logic        csr;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic [1:0]   om;
    logic [4:0]   cmd;
    fta_tranid_t  tid;
    logic [1:0]   bte;
    logic [5:0]   blen;
    logic [2:0]   cti;
    logic [3:0]   seg;
    fta_size_t    sz;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [7:0]   asid;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [15:0]  sel;
    logic [127:0] data1;
    logic [7:0]   pl;
    logic [3:0]   pri;
    logic [3:0]   cache;
    logic         csr;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t tid;
    logic [3:0]  pri;
    logic        stall;
    logic        next;
    logic        ack;
    logic        err;
    logic        rty;
    logic [31:0] adr;
    logic [31:0] dat;
  } fta_cmd_response32_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic [3:0]   pri;
    logic         stall;
    logic         next;
    logic         ack;
    logic         err;
    logic         rty;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic       v;
    logic [1:0] lane;
  } fta_lane_tag_t;

  function automatic logic [15:0] fta_sel32to128(input logic [3:0] sel, input logic [1:0] lane);
    return {12'h000, sel} << {lane, 2'b00};
  endfunction

endpackage

// File: rtl/fta_lane_tag_table.sv
// Per-tid lane tags for outstanding requests: one write port, one clear port,
// asynchronous read; a write to the entry being cleared in the same cycle wins.
module fta_lane_tag_table
  import fta_bus_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en,
  input  logic [TAGW-1:0]        wr_idx,
  input  logic [1:0]             wr_lane,
  input  logic                   clr_en,
  input  logic [TAGW-1:0]        clr_idx,
  input  logic [TAGW-1:0]        rd_idx,
  output fta_lane_tag_t          rd_tag,
  output logic [(1<<TAGW)-1:0]   valid
);

  localparam int N = 1 << TAGW;

  logic [N-1:0] valid_q;
  logic [1:0]   lane_q [N];

  // NOTE: non-blocking assignments only; the later write to valid_q overrides
  // the clear when both target the same entry, giving write-over-clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  // NOTE: lane storage is left unreset; it is only meaningful under its valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en) lane_q[wr_idx] <= wr_lane;
  end

  assign rd_tag.v    = valid_q[rd_idx];
  assign rd_tag.lane = lane_q[rd_idx];
  assign valid       = valid_q;

endmodule

// File: rtl/fta_bridge32to128.sv
// 32-bit to 128-bit FTA widening bridge with per-tid lane tags and local errors.
// Optional orphan-response counter: define FTA_B32TO128_MISS_CNT_EN.
module fta_bridge32to128
  import fta_bus_pkg::*;
#(
  parameter int TAGW = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request32_t   req32_i,
  output fta_cmd_response32_t  resp32_o,
  output fta_cmd_request128_t  req128_o,
  input  fta_cmd_response128_t resp128_i
`ifdef FTA_B32TO128_MISS_CNT_EN
  ,
  output logic [15:0]          miss_cnt_o
`endif
);

  logic [1:0]            req_lane;
  logic [TAGW-1:0]       req_idx;
  logic [TAGW-1:0]       rsp_idx;
  logic                  req_valid;
  logic                  oversize;
  logic                  collision;
  logic                  stall;
  logic                  accept;
  logic                  rsp_done;
  logic                  rsp_any;
  logic                  local_err;
  logic [1:0]            rsp_lane;
  fta_lane_tag_t         rd_tag;
  logic [(1<<TAGW)-1:0]  tag_valid;

  logic                  pend_err;
  fta_tranid_t           err_tid;
  logic [31:0]           err_adr;

  assign req_lane  = req32_i.padr[3:2];
  assign req_idx   = req32_i.tid[TAGW-1:0];
  assign rsp_idx   = resp128_i.tid[TAGW-1:0];
  assign req_valid = req32_i.cyc & req32_i.stb;
  assign oversize  = (req32_i.sz == octa) | (req32_i.sz == hexi);
  assign collision = req_valid & ~oversize & tag_valid[req_idx];
  assign stall     = resp128_i.stall | collision | pend_err;
  assign accept    = req_valid & ~stall & ~oversize;
  assign rsp_done  = resp128_i.ack | resp128_i.err;
  assign rsp_any   = rsp_done | resp128_i.rty;
  assign local_err = pend_err & ~rsp_any;
  // Orphan responses (no live tag) are steered from lane 0.
  assign rsp_lane  = rd_tag.v ? rd_tag.lane : 2'd0;

  fta_lane_tag_table #(.TAGW(TAGW)) u_tags (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (accept),
    .wr_idx  (req_idx),
    .wr_lane (req_lane),
    .clr_en  (rsp_done),
    .clr_idx (rsp_idx),
    .rd_idx  (rsp_idx),
    .rd_tag  (rd_tag),
    .valid   (tag_valid)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    req128_o       = '0;
    req128_o.om    = req32_i.om;
    req128_o.cmd   = req32_i.cmd;
    req128_o.tid   = req32_i.tid;
    req128_o.bte   = req32_i.bte;
    req128_o.blen  = req32_i.blen;
    req128_o.cti   = req32_i.cti;
    req128_o.seg   = req32_i.seg;
    req128_o.sz    = req32_i.sz;
    req128_o.cyc   = req32_i.cyc & ~oversize & ~collision;
    req128_o.stb   = req32_i.stb & ~oversize & ~collision;
    req128_o.we    = req32_i.we;
    req128_o.asid  = req32_i.asid;
    req128_o.vadr  = req32_i.vadr;
    req128_o.padr  = req32_i.padr;
    req128_o.sel   = fta_sel32to128(req32_i.sel, req_lane);
    req128_o.data1 = {4{req32_i.dat}};
    req128_o.pl    = req32_i.pl;
    req128_o.pri   = req32_i.pri;
    req128_o.cache = req32_i.cache;
    req128_o.csr   = req32_i.csr;
  end

  always_comb begin
    resp32_o       = '0;
    resp32_o.next  = resp128_i.next;
    resp32_o.stall = resp128_i.stall;
    if (!rst_i) begin
      resp32_o.stall = stall;
      // A downstream response always takes the bus; the local error waits.
      if (local_err) begin
        resp32_o.err = 1'b1;
        resp32_o.tid = err_tid;
        resp32_o.adr = err_adr;
      end else begin
        resp32_o.tid = resp128_i.tid;
        resp32_o.pri = resp128_i.pri;
        resp32_o.ack = resp128_i.ack;
        resp32_o.err = resp128_i.err;
        resp32_o.rty = resp128_i.rty;
        resp32_o.adr = resp128_i.adr;
        resp32_o.dat = resp128_i.dat[32*rsp_lane +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_err <= 1'b0;
      err_tid  <= '0;
      err_adr  <= '0;
    end else if (local_err) begin
      pend_err <= 1'b0;
    end else if (req_valid & oversize & ~stall) begin
      pend_err <= 1'b1;
      err_tid  <= req32_i.tid;
      err_adr  <= req32_i.padr;
    end
  end

`ifdef FTA_B32TO128_MISS_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_o <= '0;
    end else if (rsp_done & ~rd_tag.v & (miss_cnt_o != 16'hFFFF)) begin
      miss_cnt_o <= miss_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fta_bridge32to128.sv
// Self-checking bench for fta_bridge32to128: directed scenarios plus randomized
// traffic against a per-tid lane model kept in plain arrays.
module tb_fta_bridge32to128;
  import fta_bus_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  fta_cmd_request32_t   req32;
  fta_cmd_response32_t  resp32_o;
  fta_cmd_request128_t  req128_o;
  fta_cmd_response128_t resp128;
`ifdef FTA_B32TO128_MISS_CNT_EN
  logic [15:0]          miss_cnt_o;
`endif

  fta_bridge32to128 #(.TAGW(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req32_i   (req32),
    .resp32_o  (resp32_o),
    .req128_o  (req128_o),
    .resp128_i (resp128)
`ifdef FTA_B32TO128_MISS_CNT_EN
    ,
    .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: which tids are outstanding and at which word.
  bit          m_valid [16];
  int          m_lane  [16];
  bit          m_pend;
  fta_tranid_t m_ptid;
  logic [31:0] m_padr;
  int          m_miss;

  logic         exp_cyc, exp_stall, exp_ack, exp_err, exp_rty, exp_next;
  logic [15:0]  exp_sel;
  logic [127:0] exp_data1;
  logic [31:0]  exp_dat, exp_adr;
  fta_tranid_t  exp_tid;

  localparam logic [127:0] WORDS = 128'h44444444_33333333_22222222_11111111;

  function automatic bit is_oversize(fta_size_t s);
    return (s == octa) || (s == hexi);
  endfunction

  task automatic model_eval();
    int  lane, ri, rl;
    bit  over, coll, has_rsp;
    lane      = int'((req32.padr / 4) % 4);
    over      = is_oversize(req32.sz);
    coll      = req32.cyc && req32.stb && !over && m_valid[int'(req32.tid) % 16];
    exp_cyc   = req32.cyc && !over && !coll;
    exp_sel   = 16'(int'(req32.sel) * (16 ** lane));
    exp_data1 = {req32.dat, req32.dat, req32.dat, req32.dat};
    ri        = int'(resp128.tid) % 16;
    rl        = m_valid[ri] ? m_lane[ri] : 0;
    has_rsp   = resp128.ack || resp128.err || resp128.rty;
    exp_next  = resp128.next;
    exp_stall = resp128.stall || coll || m_pend;
    if (rst) begin
      exp_stall = resp128.stall;
      {exp_ack, exp_err, exp_rty, exp_tid, exp_adr, exp_dat} = '0;
    end else if (m_pend && !has_rsp) begin
      exp_ack = 0; exp_err = 1; exp_rty = 0;
      exp_tid = m_ptid; exp_adr = m_padr; exp_dat = 32'h0;
    end else begin
      exp_ack = resp128.ack; exp_err = resp128.err; exp_rty = resp128.rty;
      exp_tid = resp128.tid; exp_adr = resp128.adr;
      exp_dat = 32'(resp128.dat >> (32 * rl));
    end
  endtask

  task automatic model_commit();
    int  ri, qi;
    bit  over, has_rsp;
    model_eval();
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_pend = 0;
      m_miss = 0;
      return;
    end
    ri      = int'(resp128.tid) % 16;
    qi      = int'(req32.tid) % 16;
    over    = is_oversize(req32.sz);
    has_rsp = resp128.ack || resp128.err || resp128.rty;
    if (resp128.ack || resp128.err) begin
      if (!m_valid[ri] && m_miss < 65535) m_miss++;
      m_valid[ri] = 0;
    end
    if (req32.cyc && req32.stb && !exp_stall && !over) begin
      m_valid[qi] = 1;
      m_lane[qi]  = int'((req32.padr / 4) % 4);
    end
    if (m_pend && !has_rsp) m_pend = 0;
    else if (req32.cyc && req32.stb && over && !exp_stall) begin
      m_pend = 1; m_ptid = req32.tid; m_padr = req32.padr;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req32   = '0;
    req32.sz = tetra;
    resp128 = '0;
  endtask

  task automatic issue(input fta_tranid_t tid, input logic [31:0] padr, input logic we);
    idle();
    req32.cyc = 1; req32.stb = 1; req32.we = we;
    req32.tid = tid; req32.padr = padr; req32.sel = 4'hF;
    req32.dat = $urandom();
  endtask

  task automatic respond(input fta_tranid_t tid, input logic [127:0] dat);
    idle();
    resp128.ack = 1; resp128.tid = tid; resp128.dat = dat;
    resp128.adr = $urandom();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    resp128.stall = 1; resp128.next = 1; resp128.ack = 1; resp128.dat = WORDS;
    #1;
    n_total++;
    if (resp32_o !== fta_cmd_response32_t'({8'h0, 4'h0, 1'b1, 1'b1, 3'b000, 32'h0, 32'h0}))
      $display("FAIL reset_resp32 got=%h exp=stall/next only", resp32_o);
    else n_pass++;
    tick(); tick();
    idle(); rst = 0; #1;
    n_total++;
    if (resp32_o !== '0 || req128_o.cyc !== 1'b0)
      $display("FAIL reset_idle resp32=%h cyc=%b exp=0/0", resp32_o, req128_o.cyc);
    else n_pass++;
`ifdef FTA_B32TO128_MISS_CNT_EN
    n_total++;
    if (miss_cnt_o !== 16'd0) $display("FAIL reset_miss got=%0d exp=0", miss_cnt_o);
    else n_pass++;
`endif
  endtask

  task automatic test_word_write();
    issue(8'h0A, 32'h8000_1008, 1'b1);
    req32.dat = 32'h1234_5678;
    #1;
    n_total++;
    if (req128_o.sel !== 16'h0F00) $display("FAIL word_write_sel got=%h exp=0f00", req128_o.sel);
    else n_pass++;
    n_total++;
    if (req128_o.data1 !== 128'h12345678_12345678_12345678_12345678 || req128_o.cyc !== 1'b1
        || req128_o.padr !== 32'h8000_1008 || req128_o.tid !== 8'h0A)
      $display("FAIL word_write_fields data1=%h cyc=%b padr=%h", req128_o.data1, req128_o.cyc, req128_o.padr);
    else n_pass++;
    tick();
    respond(8'h0A, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h3333_3333) $display("FAIL word_write_lane2 got=%h exp=33333333", resp32_o.dat);
    else n_pass++;
    tick();
  endtask

  task automatic test_read();
    logic [127:0] d;
    d = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    issue(8'd3, 32'h0000_0004, 1'b0); #1;
    tick();
    idle(); #1; tick();
    respond(8'd3, d); #1;
    n_total++;
    if (resp32_o.dat !== 32'hBBBB_BBBB || resp32_o.ack !== 1'b1 || resp32_o.tid !== 8'd3)
      $display("FAIL read_resp dat=%h ack=%b tid=%0d exp=bbbbbbbb/1/3", resp32_o.dat, resp32_o.ack, resp32_o.tid);
    else n_pass++;
    tick();
    respond(8'd3, d); #1;
    n_total++;
    if (resp32_o.dat !== 32'hAAAA_AAAA) $display("FAIL read_tag_cleared got=%h exp=aaaaaaaa", resp32_o.dat);
    else n_pass++;
    tick();
  endtask

  task automatic test_out_of_order();
    issue(8'd1, 32'h0000_000C, 1'b0); tick();
    issue(8'd2, 32'h0000_0000, 1'b0); tick();
    idle(); tick();
    respond(8'd2, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h1111_1111) $display("FAIL ooo_tid2 got=%h exp=11111111", resp32_o.dat);
    else n_pass++;
    tick();
    respond(8'd1, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h4444_4444) $display("FAIL ooo_tid1 got=%h exp=44444444", resp32_o.dat);
    else n_pass++;
    tick();
  endtask

  task automatic test_oversize();
    issue(8'd5, 32'h0000_2010, 1'b0);
    req32.sz = octa; #1;
    n_total++;
    if (req128_o.cyc !== 1'b0 || req128_o.stb !== 1'b0 || resp32_o.stall !== 1'b0)
      $display("FAIL oversize_block cyc=%b stb=%b stall=%b exp=0/0/0", req128_o.cyc, req128_o.stb, resp32_o.stall);
    else n_pass++;
    tick();
    idle(); #1;
    n_total++;
    if (resp32_o.err !== 1'b1 || resp32_o.ack !== 1'b0 || resp32_o.tid !== 8'd5
        || resp32_o.adr !== 32'h0000_2010 || resp32_o.dat !== 32'h0 || resp32_o.stall !== 1'b1)
      $display("FAIL oversize_err got=%h exp err tid=5 adr=2010", resp32_o);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (resp32_o.err !== 1'b0 || resp32_o.stall !== 1'b0)
      $display("FAIL oversize_clear err=%b stall=%b exp=0/0", resp32_o.err, resp32_o.stall);
    else n_pass++;
    issue(8'd5, 32'h0000_3020, 1'b0);
    req32.sz = hexi; tick();
    respond(8'd9, WORDS); #1;
    n_total++;
    if (resp32_o.ack !== 1'b1 || resp32_o.err !== 1'b0 || resp32_o.tid !== 8'd9)
      $display("FAIL oversize_priority ack=%b err=%b tid=%0d exp=1/0/9", resp32_o.ack, resp32_o.err, resp32_o.tid);
    else n_pass++;
    tick();
    idle(); #1;
    n_total++;
    if (resp32_o.err !== 1'b1 || resp32_o.tid !== 8'd5 || resp32_o.adr !== 32'h0000_3020)
      $display("FAIL oversize_delayed err=%b tid=%0d adr=%h exp=1/5/3020", resp32_o.err, resp32_o.tid, resp32_o.adr);
    else n_pass++;
    tick();
  endtask

  task automatic test_collision();
    issue(8'd1, 32'h0000_0004, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      issue(8'd1, 32'h0000_0008, 1'b0); #1;
      n_total++;
      if (resp32_o.stall !== 1'b1 || req128_o.cyc !== 1'b0)
        $display("FAIL collision_hold%0d stall=%b cyc=%b exp=1/0", i, resp32_o.stall, req128_o.cyc);
      else n_pass++;
      tick();
    end
    issue(8'd1, 32'h0000_0008, 1'b0);
    resp128.ack = 1; resp128.tid = 8'd1; resp128.dat = WORDS; #1;
    n_total++;
    if (resp32_o.stall !== 1'b1 || req128_o.cyc !== 1'b0 || resp32_o.dat !== 32'h2222_2222)
      $display("FAIL collision_ackcycle stall=%b cyc=%b dat=%h exp=1/0/22222222", resp32_o.stall, req128_o.cyc, resp32_o.dat);
    else n_pass++;
    tick();
    issue(8'd1, 32'h0000_0008, 1'b0); #1;
    n_total++;
    if (resp32_o.stall !== 1'b0 || req128_o.cyc !== 1'b1)
      $display("FAIL collision_release stall=%b cyc=%b exp=0/1", resp32_o.stall, req128_o.cyc);
    else n_pass++;
    tick();
    respond(8'd1, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h3333_3333) $display("FAIL collision_newlane got=%h exp=33333333", resp32_o.dat);
    else n_pass++;
    tick();
  endtask

  task automatic test_orphan();
    idle(); rst = 1; tick(); rst = 0;
    respond(8'd7, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h1111_1111 || resp32_o.ack !== 1'b1)
      $display("FAIL orphan_lane0 dat=%h ack=%b exp=11111111/1", resp32_o.dat, resp32_o.ack);
    else n_pass++;
    tick();
`ifdef FTA_B32TO128_MISS_CNT_EN
    n_total++;
    if (miss_cnt_o !== 16'd1) $display("FAIL orphan_miss got=%0d exp=1", miss_cnt_o);
    else n_pass++;
`endif
    issue(8'd2, 32'h0000_000C, 1'b0); tick();
    idle(); rst = 1; tick(); rst = 0;
`ifdef FTA_B32TO128_MISS_CNT_EN
    #1;
    n_total++;
    if (miss_cnt_o !== 16'd0) $display("FAIL reset_miss_clear got=%0d exp=0", miss_cnt_o);
    else n_pass++;
`endif
    respond(8'd2, WORDS); #1;
    n_total++;
    if (resp32_o.dat !== 32'h1111_1111) $display("FAIL reset_drops_tag got=%h exp=11111111", resp32_o.dat);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    fta_size_t sizes [5] = '{byt, wyde, tetra, octa, hexi};
    int        pick;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      req32       = '0;
      req32.cyc   = ($urandom_range(0, 9) < 7);
      req32.stb   = ($urandom_range(0, 9) < 8);
      req32.we    = $urandom_range(0, 1);
      req32.tid   = 8'($urandom_range(0, 31));
      req32.padr  = $urandom();
      req32.sel   = 4'($urandom());
      req32.dat   = $urandom();
      req32.pri   = 4'($urandom());
      req32.sz    = sizes[($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 4)];
      resp128     = '0;
      resp128.tid   = 8'($urandom_range(0, 31));
      resp128.dat   = {$urandom(), $urandom(), $urandom(), $urandom()};
      resp128.adr   = $urandom();
      resp128.pri   = 4'($urandom());
      resp128.stall = ($urandom_range(0, 9) == 0);
      resp128.next  = $urandom_range(0, 1);
      pick = $urandom_range(0, 19);
      resp128.ack = (pick < 6);
      resp128.err = (pick == 6);
      resp128.rty = (pick == 7);
      #1;
      model_eval();
      n_total++;
      if ({req128_o.cyc, req128_o.sel, req128_o.data1, req128_o.tid, req128_o.padr, req128_o.sz}
          !== {exp_cyc, exp_sel, exp_data1, req32.tid, req32.padr, req32.sz})
        $display("FAIL rand_req c=%0d cyc=%b sel=%h exp cyc=%b sel=%h", c, req128_o.cyc, req128_o.sel, exp_cyc, exp_sel);
      else n_pass++;
      n_total++;
      if ({resp32_o.dat, resp32_o.ack, resp32_o.err, resp32_o.rty, resp32_o.tid, resp32_o.adr, resp32_o.stall, resp32_o.next}
          !== {exp_dat, exp_ack, exp_err, exp_rty, exp_tid, exp_adr, exp_stall, exp_next})
        $display("FAIL rand_resp c=%0d got dat=%h a/e/r=%b%b%b tid=%0d stall=%b exp dat=%h a/e/r=%b%b%b tid=%0d stall=%b",
                 c, resp32_o.dat, resp32_o.ack, resp32_o.err, resp32_o.rty, resp32_o.tid, resp32_o.stall,
                 exp_dat, exp_ack, exp_err, exp_rty, exp_tid, exp_stall);
      else n_pass++;
`ifdef FTA_B32TO128_MISS_CNT_EN
      n_total++;
      if (miss_cnt_o !== 16'(m_miss)) $display("FAIL rand_miss c=%0d got=%0d exp=%0d", c, miss_cnt_o, m_miss);
      else n_pass++;
`endif
      tick();
    end
    rst = 0;
  endtask

  initial begin
    foreach (m_valid[i]) begin m_valid[i] = 0; m_lane[i] = 0; end
    m_pend = 0; m_miss = 0; m_ptid = '0; m_padr = '0;
    rst = 1;
    idle();
    @(posedge clk); #1;
    test_reset();
    test_word_write();
    test_read();
    test_out_of_order();
    test_oversize();
    test_collision();
    test_orphan();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
